// File: rtl/trace_pkg.sv
// Shared trace packet format: header, entry layout, packet length and byte selection.
// TRACE_SEQ_EN adds an 8-bit sequence byte after the header (14-byte packets).
package trace_pkg;

    localparam logic [7:0] TRACE_HDR = 8'hA5;

`ifdef TRACE_SEQ_EN
    localparam int PKT_LEN = 14;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
        logic [7:0]  seq;
    } trace_entry_t;
`else
    localparam int PKT_LEN = 13;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
    } trace_entry_t;
`endif

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    localparam logic [3:0] LAST_IDX = 4'(PKT_LEN - 1);

    // Byte 0 sits in the low bits so the packet index is a plain byte shift.
    function automatic logic [7:0] pkt_byte(input trace_entry_t e, input logic [3:0] idx);
        logic [PKT_LEN*8-1:0] flat;
        logic [PKT_LEN*8-1:0] shifted;
`ifdef TRACE_SEQ_EN
        flat = {e.result, e.instr, e.pc, e.seq, TRACE_HDR};
`else
        flat = {e.result, e.instr, e.pc, TRACE_HDR};
`endif
        shifted = flat >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries; head is readable combinationally, one-cycle write.
// No internal protection: the owner pushes only when not full (or popping) and pops only when not empty.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  trace_entry_t               din,
    output trace_entry_t               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);

    trace_entry_t  mem_q [DEPTH];
    trace_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign dout  = mem_q[rd_ptr_q];
    assign level = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/trace_packetizer.sv
// Retirement trace packetizer: buffers {pc,instr,result} and streams fixed-format byte packets.
// Header appears 2 cycles after wb_valid when idle; output holds while out_ready=0, full FIFO drops and sets overflow.
// TRACE_SEQ_EN inserts a per-retirement sequence byte after the header.
module trace_packetizer
    import trace_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [31:0]                wb_pc,
    input  logic [31:0]                wb_instr,
    input  logic [31:0]                wb_result,
    output logic                       out_valid,
    output logic [7:0]                 out_data,
    input  logic                       out_ready,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    logic [0:0]   state_q, state_d;
    logic [3:0]   byte_idx_q, byte_idx_d;
    trace_entry_t payload_q, payload_d;
    logic         overflow_q, overflow_d;

    logic         hs, last, pop, push;
    logic         fifo_full, fifo_empty;
    trace_entry_t head, wr_entry;

`ifdef TRACE_SEQ_EN
    logic [7:0]   seq_q, seq_d;
`endif

    assign hs   = (state_q == SEND) && out_ready;
    assign last = (byte_idx_q == LAST_IDX);
    // Reload on the final handshake keeps back-to-back packets free of bubbles.
    assign pop  = !fifo_empty && ((state_q == IDLE) || (hs && last));
    assign push = wb_valid && (!fifo_full || pop);

    always_comb begin
        wr_entry        = '0;
        wr_entry.pc     = wb_pc;
        wr_entry.instr  = wb_instr;
        wr_entry.result = wb_result;
`ifdef TRACE_SEQ_EN
        wr_entry.seq    = seq_q;
`endif
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (wr_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        payload_d  = payload_q;
        overflow_d = overflow_q | (wb_valid && !push);
        if (pop) begin
            payload_d  = head;
            byte_idx_d = '0;
            state_d    = SEND;
        end else if (hs) begin
            if (last) begin
                state_d = IDLE;
            end else begin
                byte_idx_d = byte_idx_q + 1'b1;
            end
        end
    end

`ifdef TRACE_SEQ_EN
    // Dropped retirements still consume a number so the host sees the gap.
    always_comb begin
        seq_d = seq_q;
        if (wb_valid) begin
            seq_d = seq_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q <= '0;
        end else begin
            seq_q <= seq_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_idx_q <= '0;
            payload_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            payload_q  <= payload_d;
            overflow_q <= overflow_d;
        end
    end

    assign out_valid = (state_q == SEND);
    assign out_data  = out_valid ? pkt_byte(payload_q, byte_idx_q) : 8'h00;
    assign overflow  = overflow_q;

endmodule
